// File: rtl/pts_tx_sched.sv
// pts_tx_sched: round-robin transmit scheduler for a parallel-to-serial
// shift register. Accepts words from two requesters, loads the shift
// register, paces shifts so each bit is held CLKS_PER_BIT clocks, and
// supports a synchronous abort that parks the serial line at idle (1).
module pts_tx_sched #(
    parameter int NUM_BITS     = 32,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                req0_valid,
    input  logic [NUM_BITS-1:0] req0_data,
    output logic                req0_ready,
    input  logic                req1_valid,
    input  logic [NUM_BITS-1:0] req1_data,
    output logic                req1_ready,
    input  logic                abort,
    output logic                sr_load_enable,
    output logic                sr_shift_enable,
    output logic [NUM_BITS-1:0] sr_parallel_in,
    output logic                tx_active,
    output logic                tx_src,
    output logic                frame_done
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CW = $clog2(NUM_BITS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_BIT  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [NUM_BITS-1:0] r_word;
    logic                r_last_src;
    logic                r_tx_src;
    logic [TW-1:0]       r_timer;
    logic [CW-1:0]       r_bitcnt;

    logic w_grant0;
    logic w_grant1;
    logic w_accept;
    logic w_tc;
    logic w_last_bit;

    // Round-robin grant: a lone requester wins; on a tie the one not served last wins
    always_comb begin
        w_grant0 = req0_valid && (!req1_valid || r_last_src);
        w_grant1 = req1_valid && (!req0_valid || !r_last_src);
    end

    // Ready is combinational and held low while reset is asserted
    always_comb begin
        req0_ready = n_rst && (r_state == S_IDLE) && w_grant0;
        req1_ready = n_rst && (r_state == S_IDLE) && w_grant1;
        w_accept   = (req0_ready && req0_valid) || (req1_ready && req1_valid);
        w_tc       = (r_timer == TW'(CLKS_PER_BIT - 1));
        w_last_bit = (r_bitcnt == CW'(NUM_BITS - 1));
    end

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; abort outranks the final terminal count
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_next = S_LOAD;
            S_LOAD: w_state_next = abort ? S_IDLE : S_BIT;
            S_BIT: begin
                if (abort)                 w_state_next = S_IDLE;
                else if (w_tc && w_last_bit) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Shift-register controls; an abort reloads all-ones to force the line idle
    always_comb begin
        sr_load_enable  = 1'b0;
        sr_shift_enable = 1'b0;
        sr_parallel_in  = r_word;
        frame_done      = 1'b0;
        case (r_state)
            S_LOAD: begin
                sr_load_enable = 1'b1;
                if (abort) sr_parallel_in = '1;
            end
            S_BIT: begin
                if (abort) begin
                    sr_load_enable = 1'b1;
                    sr_parallel_in = '1;
                end else if (w_tc) begin
                    sr_shift_enable = 1'b1;
                    frame_done      = w_last_bit;
                end
            end
            default: ;
        endcase
        tx_active = (r_state != S_IDLE);
        tx_src    = r_tx_src;
    end

    // Capture the accepted word and remember who sent it
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_word     <= '0;
            r_last_src <= 1'b1;
            r_tx_src   <= 1'b0;
        end else if (w_accept) begin
            r_word     <= req1_ready ? req1_data : req0_data;
            r_last_src <= req1_ready;
            r_tx_src   <= req1_ready;
        end
    end

    // Bit timer and bit counter; both restart in LOAD so neither wraps mid-frame
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_timer  <= '0;
            r_bitcnt <= '0;
        end else if (r_state == S_LOAD) begin
            r_timer  <= '0;
            r_bitcnt <= '0;
        end else if (r_state == S_BIT) begin
            if (w_tc) begin
                r_timer  <= '0;
                r_bitcnt <= r_bitcnt + 1'b1;
            end else begin
                r_timer  <= r_timer + 1'b1;
            end
        end
    end

endmodule
